// File: rtl/fifo_sync_pkg.sv
// ============================================================================
// Module  : fifo_sync_pkg
// Brief   : Width helpers and parameter-legality functions for fifo_sync.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_sync_pkg;

  // Constant-evaluable ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int width, input int depth, input int afull);
    return (width >= 1) && (depth >= 2) && is_pow2(depth) &&
           (afull >= 1) && (afull <= depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync_if.sv
// ============================================================================
// Module  : fifo_sync_if
// Brief   : Write/read handshake, flags and occupancy bundle for fifo_sync.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_sync_if
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic                      i_wr_en;
  logic [WIDTH-1:0]          i_wr_data;
  logic                      o_full;
  logic                      o_almost_full;
  logic                      i_rd_en;
  logic [WIDTH-1:0]          o_rd_data;
  logic                      o_not_empty;
  logic [cnt_w(DEPTH)-1:0]   o_count;
  logic                      o_overflow;
  logic                      o_underflow;

  modport master (
    output i_wr_en, i_wr_data, i_rd_en,
    input  o_full, o_almost_full, o_rd_data, o_not_empty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en,
    output o_full, o_almost_full, o_rd_data, o_not_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

`default_nettype wire

// File: rtl/fifo_sync_ram.sv
// ============================================================================
// Module  : fifo_sync_ram
// Brief   : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync_ram
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  wire logic             i_clk,
  input  wire logic             i_wr_en,
  input  wire logic [PW-1:0]    i_wr_addr,
  input  wire logic [WIDTH-1:0] i_wr_data,
  input  wire logic [PW-1:0]    i_rd_addr,
  output logic      [WIDTH-1:0] o_rd_data
);

  // Contents are deliberately not reset so the array maps onto plain RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/fifo_sync.sv
// ============================================================================
// Module  : fifo_sync
// Brief   : Single-clock FWFT FIFO with flags, count and sticky error bits.
//           Optional macro FIFO_SYNC_BYPASS_EN: write-to-read bypass when empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  wire logic  i_clk,
  input  wire logic  i_rst,
  fifo_sync_if.slave bus
);

  localparam int c_PW = ptr_w(DEPTH);
  localparam int c_CW = cnt_w(DEPTH);

  if (!params_ok(WIDTH, DEPTH, AFULL_LEVEL)) begin : g_bad_params
    $error("fifo_sync: illegal WIDTH/DEPTH/AFULL_LEVEL combination");
  end

  logic [c_PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             w_full;
  logic             w_not_empty;
  logic             w_bypass;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_ram_rd_data;

  assign w_full = (count_q == c_CW'(DEPTH));

`ifdef FIFO_SYNC_BYPASS_EN
  // An empty FIFO presents the incoming word directly; if it is also read,
  // both pointers advance together and the stored copy is never seen.
  assign w_bypass      = (count_q == '0) && bus.i_wr_en;
  assign bus.o_rd_data = w_bypass ? bus.i_wr_data : w_ram_rd_data;
`else
  assign w_bypass      = 1'b0;
  assign bus.o_rd_data = w_ram_rd_data;
`endif

  assign w_not_empty = (count_q != '0) || w_bypass;
  assign w_rd_ok     = bus.i_rd_en && w_not_empty;
  assign w_wr_ok     = bus.i_wr_en && (!w_full || w_rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  || (bus.i_wr_en && !w_wr_ok);
    underflow_d = underflow_q || (bus.i_rd_en && !w_rd_ok);
    if (w_wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_wr_ok && !w_rd_ok)      count_d = count_q + 1'b1;
    else if (w_rd_ok && !w_wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage writes are gated by reset so requests in the reset cycle are inert.
  fifo_sync_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (c_PW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_ok && !i_rst),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (bus.i_wr_data),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (w_ram_rd_data)
  );

  assign bus.o_full        = w_full;
  assign bus.o_almost_full = (count_q >= c_CW'(AFULL_LEVEL));
  assign bus.o_not_empty   = w_not_empty;
  assign bus.o_count       = count_q;
  assign bus.o_overflow    = overflow_q;
  assign bus.o_underflow   = underflow_q;

endmodule

`default_nettype wire
